// File: rtl/core_pkg.sv
// Shared RV32I core definitions: major opcode constants, the fetch FSM
// encoding and the default reset vector.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular instruction buffer with flush; the head entry is presented
// combinationally so decode sees it in the same cycle it becomes valid.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW:0]      count_reg;
    logic [DEPTH-1:0] wr_en;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && (count_reg != '0) && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = do_push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_reg[i] <= push_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == (PW + 1)'(DEPTH));
    assign empty = (count_reg == '0);

    overflow_check: assert property (@(posedge clk) disable iff (reset)
        !(push && !flush && full && !do_pop));

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: keeps the PC, issues single-outstanding word reads,
// buffers responses and hands them to decode; taken branches redirect and flush.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int                 DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        funct3
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          state_reg, state_next;
    logic [ADDR_W-1:0]     pc_reg, pc_next;
    logic [ADDR_W-1:0]     req_pc_reg;
    logic [CW-1:0]         buf_count;
    logic [CW-1:0]         post_push_count;
    logic                  buf_full, buf_empty, buf_push, buf_pop;
    logic                  issue;
    logic [31+ADDR_W:0]    buf_head;

    assign buf_pop  = !buf_empty && instr_ready && !redirect_valid;
    assign buf_push = (state_reg == WAIT) && imem_rvalid && !redirect_valid && !reset;
    assign post_push_count = buf_count + CW'(1) - CW'(buf_pop);

    // Back-to-back issue is allowed only when the returning word still leaves room.
    always_comb begin
        issue = 1'b0;
        if (!reset && !redirect_valid) begin
            case (state_reg)
                IDLE:    issue = !buf_full;
                WAIT:    issue = imem_rvalid && (post_push_count < CW'(DEPTH));
                default: issue = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_target & ~ADDR_W'(3);
            case (state_reg)
                WAIT, DROP: state_next = imem_rvalid ? IDLE : DROP;
                default:    state_next = IDLE;
            endcase
        end else if (issue) begin
            pc_next    = pc_reg + ADDR_W'(4);
            state_next = WAIT;
        end else if (state_reg != IDLE && imem_rvalid) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            req_pc_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (issue) begin
                req_pc_reg <= pc_reg;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (buf_push),
        .push_data ({imem_rdata, req_pc_reg}),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc_reg;
    assign instr_valid = !buf_empty;
    assign instr       = buf_head[31+ADDR_W:ADDR_W];
    assign instr_pc    = buf_head[ADDR_W-1:0];
    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];

endmodule
